instruction_memory_sync: RTL and testbench

//  Parametrised, clocked instruction memory for the processor fetch stage.
//  - Byte-addressed fetch port with valid/ready request and response handshakes.
//  - Separate program-load write port.
//  - After reset, a hardware sweep clears every word to NOP.
//  - Out-of-range and misaligned fetches are flagged as faults.
//  - Sits between the PC/fetch unit and the decode stage.

---
 rtl/instruction_memory_sync.sv | 85 ++++++++
 tb/tb_instruction_memory_sync.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_sync.sv
// Fetch-stage instruction memory. After reset a hardware sweep clears every word
// to NOP. It then serves 1-cycle-latency fetches and accepts program-load writes.
module instruction_memory_sync #(
  parameter int unsigned          DATA_W = 32,
  parameter int unsigned          ADDR_W = 32,
  parameter int unsigned          DEPTH  = 1024,
  parameter logic [DATA_W-1:0]    NOP    = 32'h00000000,
  localparam int unsigned         IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_fault,
  input  logic              ld_we,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W:0]    LIMIT    = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

  state_t                 state;
  logic [IDX_W-1:0]       cnt;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic                   accept;
  logic                   fault;
  logic [IDX_W-1:0]       idx;

  assign busy      = (state == CLEAR);
  assign ld_ready  = (state == RUN);
  assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[IDX_W+1:2];
  assign fault     = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= LIMIT);

  // Sweep writes and load writes share the single memory write port; the two
  // never overlap because they belong to different states.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[cnt] <= NOP;
      else if (ld_we)
        mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_instr <= NOP;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) state <= RUN;
        end
        RUN: state <= RUN;
        default: state <= CLEAR;
      endcase
      // The memory read uses the pre-edge contents, so a same-cycle load of the
      // same word returns the old value.
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_fault <= fault;
        rsp_instr <= fault ? NOP : mem[idx];
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench for instruction_memory_sync: sweep timing, fetch/fault, load
// ordering, backpressure and reset during the sweep.
module tb_instruction_memory_sync;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
  logic        ld_we, ld_ready, busy;
  logic [31:0] req_addr, rsp_instr, ld_data;
  logic [9:0]  ld_addr;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  instruction_memory_sync dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_fault(rsp_fault),
    .ld_we(ld_we), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // single accepted fetch with rsp_ready high; returns the registered response
  task automatic fetch(input logic [31:0] a, output logic v, output logic [31:0] ins,
                       output logic f);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    tick();
    v = rsp_valid; ins = rsp_instr; f = rsp_fault;
    req_valid = 1'b0;
    tick();
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++; if ({busy, req_ready, ld_ready} !== 3'b100) $display("FAIL reset_ready busy/req/ld=%b req=100", {busy, req_ready, ld_ready}); else pass_cnt++;
    total++; if ({rsp_valid, rsp_fault} !== 2'b00) $display("FAIL reset_rsp valid/fault=%b req=00", {rsp_valid, rsp_fault}); else pass_cnt++;
    total++; if (rsp_instr !== 32'h0) $display("FAIL reset_instr got=%h req=00000000", rsp_instr); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_sweep();
    int n = 0;
    logic v, f; logic [31:0] ins;
    while (busy === 1'b1 && n < 3000) begin tick(); n++; end
    total++; if (n !== 1024) $display("FAIL sweep_len got=%0d req=1024", n); else pass_cnt++;
    total++; if ({req_ready, ld_ready} !== 2'b11) $display("FAIL run_ready req/ld=%b req=11", {req_ready, ld_ready}); else pass_cnt++;
    fetch(32'h0, v, ins, f);
    total++; if ({v, f, ins} !== {2'b10, 32'h0}) $display("FAIL fetch0 v/f/instr=%b/%b/%h req=1/0/00000000", v, f, ins); else pass_cnt++;
  endtask

  task automatic test_load_fetch();
    logic v, f; logic [31:0] ins;
    load(10'd5, 32'hDEADBEEF);
    fetch(32'h14, v, ins, f);
    total++; if ({v, f, ins} !== {2'b10, 32'hDEADBEEF}) $display("FAIL load_fetch v/f/instr=%b/%b/%h req=1/0/deadbeef", v, f, ins); else pass_cnt++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rsp_clear got=%b req=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_fault();
    logic v, f; logic [31:0] ins;
    fetch(32'h16, v, ins, f);
    total++; if ({v, f, ins} !== {2'b11, 32'h0}) $display("FAIL misalign v/f/instr=%b/%b/%h req=1/1/00000000", v, f, ins); else pass_cnt++;
    fetch(32'h1000, v, ins, f);
    total++; if ({v, f, ins} !== {2'b11, 32'h0}) $display("FAIL range v/f/instr=%b/%b/%h req=1/1/00000000", v, f, ins); else pass_cnt++;
    load(10'd1023, 32'h0BADF00D);
    fetch(32'hFFC, v, ins, f);
    total++; if ({v, f, ins} !== {2'b10, 32'h0BADF00D}) $display("FAIL last_word v/f/instr=%b/%b/%h req=1/0/0badf00d", v, f, ins); else pass_cnt++;
    fetch(32'hFFFFFFFC, v, ins, f);
    total++; if ({v, f, ins} !== {2'b11, 32'h0}) $display("FAIL high_addr v/f/instr=%b/%b/%h req=1/1/00000000", v, f, ins); else pass_cnt++;
  endtask

  task automatic test_rbw();
    logic v, f; logic [31:0] ins;
    load(10'd3, 32'h11111111);
    ld_we = 1'b1; ld_addr = 10'd3; ld_data = 32'h22222222;
    req_valid = 1'b1; req_addr = 32'hC; rsp_ready = 1'b1;
    tick();
    ld_we = 1'b0; req_valid = 1'b0;
    total++; if ({rsp_valid, rsp_instr} !== {1'b1, 32'h11111111}) $display("FAIL rbw_old v/instr=%b/%h req=1/11111111", rsp_valid, rsp_instr); else pass_cnt++;
    tick();
    fetch(32'hC, v, ins, f);
    total++; if ({v, ins} !== {1'b1, 32'h22222222}) $display("FAIL rbw_new v/instr=%b/%h req=1/22222222", v, ins); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    load(10'd0, 32'hA0); load(10'd1, 32'hA1); load(10'd2, 32'hA2);
    req_valid = 1'b1; req_addr = 32'h14; rsp_ready = 1'b0;
    tick();
    req_addr = 32'h0;
    total++; if (req_ready !== 1'b0) $display("FAIL stall_ready got=%b req=0", req_ready); else pass_cnt++;
    tick(); tick(); tick();
    total++; if ({rsp_valid, rsp_instr} !== {1'b1, 32'hDEADBEEF}) $display("FAIL stall_hold v/instr=%b/%h req=1/deadbeef", rsp_valid, rsp_instr); else pass_cnt++;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL unstall_ready got=%b req=1", req_ready); else pass_cnt++;
    tick();
    total++; if ({rsp_valid, rsp_instr} !== {1'b1, 32'hA0}) $display("FAIL b2b_0 v/instr=%b/%h req=1/000000a0", rsp_valid, rsp_instr); else pass_cnt++;
    req_addr = 32'h4;
    tick();
    total++; if ({rsp_valid, rsp_instr} !== {1'b1, 32'hA1}) $display("FAIL b2b_1 v/instr=%b/%h req=1/000000a1", rsp_valid, rsp_instr); else pass_cnt++;
    req_addr = 32'h8;
    tick();
    total++; if ({rsp_valid, rsp_instr} !== {1'b1, 32'hA2}) $display("FAIL b2b_2 v/instr=%b/%h req=1/000000a2", rsp_valid, rsp_instr); else pass_cnt++;
    req_valid = 1'b0;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL b2b_drain got=%b req=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_reset_midway();
    int n = 0;
    logic v, f; logic [31:0] ins;
    req_valid = 1'b1; req_addr = 32'h14; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1) $display("FAIL pre_reset_valid got=%b req=1", rsp_valid); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0; rsp_ready = 1'b1;
    total++; if ({rsp_valid, busy} !== 2'b01) $display("FAIL reset_discard valid/busy=%b req=01", {rsp_valid, busy}); else pass_cnt++;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    while (busy === 1'b1 && n < 3000) begin
      if (n == 200) begin
        ld_we = 1'b1; ld_addr = 10'd5; ld_data = 32'h12345678;
        #1;
        total++; if (ld_ready !== 1'b0) $display("FAIL sweep_ld_ready got=%b req=0", ld_ready); else pass_cnt++;
      end
      tick();
      ld_we = 1'b0;
      n++;
    end
    total++; if (n !== 1024) $display("FAIL resweep_len got=%0d req=1024", n); else pass_cnt++;
    fetch(32'h14, v, ins, f);
    total++; if ({v, f, ins} !== {2'b10, 32'h0}) $display("FAIL resweep_clear v/f/instr=%b/%b/%h req=1/0/00000000", v, f, ins); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    #2;
    test_reset();
    test_sweep();
    test_load_fetch();
    test_fault();
    test_rbw();
    test_back_to_back();
    test_reset_midway();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
